// File: rtl/hazard_pkg.sv
// Shared constants and types for the hazard unit: forwarding-mux selects,
// stall-cause indices, and the MDU scoreboard counter-width helper.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        STALL_LW = 2'd0,
        STALL_BR = 2'd1,
        STALL_MD = 2'd2
    } stallCauseT;

    localparam int unsigned NUM_STALL_CAUSES = 3;

    // Bits needed to hold a countdown from lat to 0.
    function automatic int unsigned cntBits(input int unsigned lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/mdu_scoreboard.sv
// Tracks the single in-flight MDU result. It reloads when an MDU op enters E
// and counts down to the cycle in which the result is written (cnt == 1).
module mdu_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned MDU_LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic mdstartE,
    output logic mdubusy,
    output logic busyGt1
);

    localparam int unsigned CW = cntBits(MDU_LAT);

    logic [CW-1:0] cnt;

    // A new op restarts the countdown even if a previous one is still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (mdstartE) begin
            cnt <= CW'(MDU_LAT);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign mdubusy = (cnt != '0);
    assign busyGt1 = (cnt > CW'(1));

endmodule

// File: rtl/hazard_mc.sv
// Hazard unit for the 5-stage MIPS core with a multi-cycle MDU scoreboard.
// Optional stall perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_mc
    import hazard_pkg::*;
#(
    parameter int unsigned REGBITS = 5,
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned CNTW    = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [REGBITS-1:0] rsD,
    input  logic [REGBITS-1:0] rtD,
    input  logic [REGBITS-1:0] rsE,
    input  logic [REGBITS-1:0] rtE,
    input  logic [REGBITS-1:0] writeregE,
    input  logic [REGBITS-1:0] writeregM,
    input  logic [REGBITS-1:0] writeregW,
    input  logic               regwriteE,
    input  logic               regwriteM,
    input  logic               regwriteW,
    input  logic               memtoregE,
    input  logic               memtoregM,
    input  logic               branchD,
    input  logic               hiloD,
    input  logic               mdstartE,
    output logic               forwardaD,
    output logic               forwardbD,
    output logic [1:0]         forwardaE,
    output logic [1:0]         forwardbE,
    output logic               stallF,
    output logic               stallD,
    output logic               flushE,
    output logic               mdubusy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNTW-1:0]    lwstallcnt,
    output logic [CNTW-1:0]    brstallcnt,
    output logic [CNTW-1:0]    mdstallcnt
`endif
);

    logic lwstall;
    logic brstall;
    logic mdstall;
    logic busyGt1;
    logic eHit;
    logic mHit;

    mdu_scoreboard #(
        .MDU_LAT (MDU_LAT)
    ) uScoreboard (
        .clk      (clk),
        .reset    (reset),
        .mdstartE (mdstartE),
        .mdubusy  (mdubusy),
        .busyGt1  (busyGt1)
    );

    // M->D forwarding for the branch comparator; $0 is never forwarded.
    assign forwardaD = (rsD != '0) && (rsD == writeregM) && regwriteM;
    assign forwardbD = (rtD != '0) && (rtD == writeregM) && regwriteM;

    // E operand select, the younger M result wins over W.
    always_comb begin
        forwardaE = FWD_RF;
        forwardbE = FWD_RF;
        if ((rsE != '0) && (rsE == writeregM) && regwriteM) begin
            forwardaE = FWD_MEM;
        end else if ((rsE != '0) && (rsE == writeregW) && regwriteW) begin
            forwardaE = FWD_WB;
        end
        if ((rtE != '0) && (rtE == writeregM) && regwriteM) begin
            forwardbE = FWD_MEM;
        end else if ((rtE != '0) && (rtE == writeregW) && regwriteW) begin
            forwardbE = FWD_WB;
        end
    end

    assign lwstall = memtoregE && (rtE != '0) && ((rtE == rsD) || (rtE == rtD));

    assign eHit = regwriteE && (writeregE != '0)
                  && ((writeregE == rsD) || (writeregE == rtD));
    assign mHit = memtoregM && (writeregM != '0)
                  && ((writeregM == rsD) || (writeregM == rtD));
    assign brstall = branchD && (eHit || mHit);

    // The result lands at the end of the cnt==1 cycle, so a reader then is safe.
    assign mdstall = hiloD && (mdstartE || busyGt1);

    assign stallD = lwstall || brstall || mdstall;
    assign stallF = stallD;
    assign flushE = stallD;

`ifdef HAZARD_PERF_CNT_EN
    logic [NUM_STALL_CAUSES-1:0] cause;
    logic [CNTW-1:0]             perfCnt [NUM_STALL_CAUSES];

    assign cause[STALL_LW] = lwstall;
    assign cause[STALL_BR] = brstall;
    assign cause[STALL_MD] = mdstall;

    // Independent saturating counters; coincident causes all count.
    for (genvar g = 0; g < NUM_STALL_CAUSES; g++) begin : gPerf
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                perfCnt[g] <= '0;
            end else if (cause[g] && (perfCnt[g] != '1)) begin
                perfCnt[g] <= perfCnt[g] + CNTW'(1);
            end
        end
    end

    assign lwstallcnt = perfCnt[STALL_LW];
    assign brstallcnt = perfCnt[STALL_BR];
    assign mdstallcnt = perfCnt[STALL_MD];
`else
    // The counter width only matters when the perf counters are built.
    logic [CNTW-1:0] unusedPerfWidth;
    assign unusedPerfWidth = '0;
`endif

endmodule

// File: tb/tb_hazard_mc.sv
// Bench for hazard_mc: directed vectors, literal expectations and a
// rule-level reference model compared on every falling clock edge.
module tb_hazard_mc;

    localparam int unsigned RB  = 5;
    localparam int          LAT = 4;
    localparam int unsigned CW  = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [RB-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic          regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic          branchD, hiloD, mdstartE;
    logic          forwardaD, forwardbD, stallF, stallD, flushE, mdubusy;
    logic [1:0]    forwardaE, forwardbE;
`ifdef HAZARD_PERF_CNT_EN
    logic [CW-1:0] lwstallcnt, brstallcnt, mdstallcnt;
`endif

    int nAssert = 0;
    int nFail   = 0;

    hazard_mc #(.REGBITS(RB), .MDU_LAT(LAT), .CNTW(CW)) dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .hiloD(hiloD), .mdstartE(mdstartE),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .stallF(stallF), .stallD(stallD), .flushE(flushE), .mdubusy(mdubusy)
`ifdef HAZARD_PERF_CNT_EN
        , .lwstallcnt(lwstallcnt), .brstallcnt(brstallcnt), .mdstallcnt(mdstallcnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: MDU tracked as the cycle number of the last start.
    int cyc = 0;
    int lastStart = -1000;
    int mLw = 0, mBr = 0, mMd = 0;

    function automatic logic mFwdD(input logic [RB-1:0] src);
        return (src != 0) && (src == writeregM) && regwriteM;
    endfunction

    function automatic logic [1:0] mFwdE(input logic [RB-1:0] src);
        if (src != 0 && src == writeregM && regwriteM) return 2'b10;
        if (src != 0 && src == writeregW && regwriteW) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic mLwStall();
        return memtoregE && (rtE != 0) && (rtE == rsD || rtE == rtD);
    endfunction

    function automatic logic mBrStall();
        logic e, m;
        e = regwriteE && (writeregE != 0) && (writeregE == rsD || writeregE == rtD);
        m = memtoregM && (writeregM != 0) && (writeregM == rsD || writeregM == rtD);
        return branchD && (e || m);
    endfunction

    function automatic logic mBusy();
        int age;
        age = cyc - lastStart;
        return (age >= 1) && (age <= LAT);
    endfunction

    function automatic logic mMdStall();
        int age;
        age = cyc - lastStart;
        return hiloD && (mdstartE || ((age >= 1) && (age <= LAT - 1)));
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            lastStart <= -1000;
            mLw <= 0; mBr <= 0; mMd <= 0;
        end else begin
            if (mdstartE) lastStart <= cyc;
            if (mLwStall()) mLw <= mLw + 1;
            if (mBrStall()) mBr <= mBr + 1;
            if (mMdStall()) mMd <= mMd + 1;
        end
    end

    always @(negedge clk) begin
        logic st;
        st = mLwStall() || mBrStall() || mMdStall();
        chk("model_forwardaD", 32'(forwardaD), 32'(mFwdD(rsD)));
        chk("model_forwardbD", 32'(forwardbD), 32'(mFwdD(rtD)));
        chk("model_forwardaE", 32'(forwardaE), 32'(mFwdE(rsE)));
        chk("model_forwardbE", 32'(forwardbE), 32'(mFwdE(rtE)));
        chk("model_stallD", 32'(stallD), 32'(st));
        chk("model_stallF", 32'(stallF), 32'(st));
        chk("model_flushE", 32'(flushE), 32'(st));
        chk("model_mdubusy", 32'(mdubusy), 32'(mBusy()));
`ifdef HAZARD_PERF_CNT_EN
        chk("model_lwstallcnt", lwstallcnt, 32'(mLw));
        chk("model_brstallcnt", brstallcnt, 32'(mBr));
        chk("model_mdstallcnt", mdstallcnt, 32'(mMd));
`endif
    end

    task automatic idle();
        rsD = '0; rtD = '0; rsE = '0; rtE = '0;
        writeregE = '0; writeregM = '0; writeregW = '0;
        regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
        memtoregE = 1'b0; memtoregM = 1'b0;
        branchD = 1'b0; hiloD = 1'b0; mdstartE = 1'b0;
    endtask

    task automatic nextCyc();
        @(posedge clk);
        #1;
    endtask

    logic expMdStall [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic expMdBusy  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic expReBusy  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        reset = 1'b1;
        idle();
        nextCyc();
        @(negedge clk);
        chk("rst_stallD", 32'(stallD), 32'd0);
        chk("rst_mdubusy", 32'(mdubusy), 32'd0);
        chk("rst_forwardaE", 32'(forwardaE), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        chk("rst_mdstallcnt", mdstallcnt, 32'd0);
`endif
        nextCyc();
        reset = 1'b0;

        // load-use on $8
        nextCyc();
        memtoregE = 1'b1; rtE = 5'd8; rsD = 5'd8; regwriteE = 1'b1; writeregE = 5'd8;
        @(negedge clk);
        chk("lw_stallD", 32'(stallD), 32'd1);
        chk("lw_stallF", 32'(stallF), 32'd1);
        chk("lw_flushE", 32'(flushE), 32'd1);
        nextCyc();
        idle();
        @(negedge clk);
        chk("lw_release", 32'(stallD), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        chk("lw_cnt", lwstallcnt, 32'd1);
`endif

        // E forwarding priority
        nextCyc();
        rsE = 5'd9; rtE = 5'd9; writeregM = 5'd9; writeregW = 5'd9;
        regwriteM = 1'b1; regwriteW = 1'b1;
        @(negedge clk);
        chk("fwdE_mem", 32'(forwardaE), 32'd2);
        chk("fwdE_mem_b", 32'(forwardbE), 32'd2);
        nextCyc();
        regwriteM = 1'b0;
        @(negedge clk);
        chk("fwdE_wb", 32'(forwardaE), 32'd1);
        nextCyc();
        rsE = 5'd0; writeregW = 5'd0;
        @(negedge clk);
        chk("fwdE_r0", 32'(forwardaE), 32'd0);
        chk("fwdE_wb_b", 32'(forwardbE), 32'd0);

        // branch hazards
        nextCyc();
        idle();
        branchD = 1'b1; rsD = 5'd4; writeregE = 5'd4; regwriteE = 1'b1;
        @(negedge clk);
        chk("br_stallE", 32'(stallD), 32'd1);
        chk("br_noFwd", 32'(forwardaD), 32'd0);
        nextCyc();
        writeregE = 5'd0; regwriteE = 1'b0;
        writeregM = 5'd4; regwriteM = 1'b1; memtoregM = 1'b0;
        @(negedge clk);
        chk("br_noStall", 32'(stallD), 32'd0);
        chk("br_fwdaD", 32'(forwardaD), 32'd1);
        nextCyc();
        rtD = 5'd5; writeregM = 5'd5; memtoregM = 1'b1;
        @(negedge clk);
        chk("br_stallLoadM", 32'(stallD), 32'd1);
        chk("br_fwdbD", 32'(forwardbD), 32'd1);
        nextCyc();
        idle();
`ifdef HAZARD_PERF_CNT_EN
        @(negedge clk);
        chk("br_cnt", brstallcnt, 32'd2);
`endif

        // MDU op with a HI/LO reader held in D
        for (int i = 0; i < 6; i++) begin
            nextCyc();
            mdstartE = (i == 0);
            hiloD = 1'b1;
            @(negedge clk);
            chk($sformatf("md_stall_c%0d", i), 32'(stallD), 32'(expMdStall[i]));
            chk($sformatf("md_busy_c%0d", i), 32'(mdubusy), 32'(expMdBusy[i]));
        end
`ifdef HAZARD_PERF_CNT_EN
        chk("md_cnt", mdstallcnt, 32'd4);
`endif

        // reset in the middle of an MDU op
        nextCyc();
        mdstartE = 1'b1; hiloD = 1'b1;
        nextCyc();
        mdstartE = 1'b0;
        nextCyc();
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_stallD", 32'(stallD), 32'd0);
        chk("rstmid_busy", 32'(mdubusy), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        chk("rstmid_cnt", mdstallcnt, 32'd0);
`endif
        nextCyc();
        reset = 1'b0;
        @(negedge clk);
        chk("rstmid_after", 32'(stallD), 32'd0);

        // restart while busy
        idle();
        for (int i = 0; i < 8; i++) begin
            nextCyc();
            mdstartE = (i == 0) || (i == 2);
            @(negedge clk);
            chk($sformatf("restart_busy_c%0d", i), 32'(mdubusy), 32'(expReBusy[i]));
        end

        nextCyc();
        idle();
        nextCyc();
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
